bp_io_packet_arbiter: RTL and testbench

Parametrised N-channel wormhole packet arbiter for the I/O tile's outbound I/O NoC port. It merges `num_channels_p` ready/valid flit streams, such as socket command sources, into one output stream. Arbitration is at packet granularity: a granted channel keeps the output until its tail flit is accepted. Round-robin or fixed-priority mode is selected by parameter, and a two-entry output buffer decouples `ready_i` timing from the inputs.

---
 rtl/bp_io_packet_arbiter.sv | 160 ++++++++++++++++
 tb/tb_bp_io_packet_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_io_packet_arbiter.sv
// N-channel wormhole packet arbiter: packet-granular round-robin or fixed-priority
// merge of ready/valid flit streams into one output through a 2-entry buffer.
module bp_io_packet_arbiter #(
  parameter int unsigned num_channels_p = 4,
  parameter int unsigned flit_width_p   = 64,
  parameter int unsigned len_width_p    = 4,
  parameter bit          rr_mode_p      = 1'b1
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic [num_channels_p*flit_width_p-1:0] data_i,
  input  logic [num_channels_p-1:0]              v_i,
  output logic [num_channels_p-1:0]              ready_o,
  output logic [flit_width_p-1:0]                data_o,
  output logic                                   v_o,
  input  logic                                   ready_i,
  output logic [num_channels_p-1:0]              grant_o,
  output logic                                   busy_o
);

  localparam int unsigned ch_w = (num_channels_p > 1) ? $clog2(num_channels_p) : 1;

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic [len_width_p-1:0]  remaining_q, remaining_d;
  logic [ch_w-1:0]         owner_q, owner_d;
  logic [ch_w-1:0]         ptr_q, ptr_d;

  logic [ch_w-1:0]         winner;
  logic                    winner_v;
  logic [ch_w:0]           idx_sum;
  logic [ch_w-1:0]         idx;
  logic [ch_w-1:0]         sel;
  logic [flit_width_p-1:0] sel_flit;
  logic [len_width_p-1:0]  sel_len;
  logic                    space;
  logic                    accept;
  logic                    pop;

  logic [flit_width_p-1:0] fifo_mem [2];
  logic                    fifo_wr_q;
  logic                    fifo_rd_q;
  logic [1:0]              fifo_cnt_q;

  function automatic logic [ch_w-1:0] next_ptr(input logic [ch_w-1:0] c);
    if (!rr_mode_p) return '0;
    return (c == ch_w'(num_channels_p - 1)) ? '0 : c + ch_w'(1);
  endfunction

  // First requesting channel, searching from the pointer (pointer stays 0 in fixed mode)
  always_comb begin
    winner   = '0;
    winner_v = 1'b0;
    idx_sum  = '0;
    idx      = '0;
    for (int unsigned i = 0; i < num_channels_p; i++) begin
      idx_sum = {1'b0, ptr_q} + (ch_w+1)'(i);
      if (idx_sum >= (ch_w+1)'(num_channels_p)) idx_sum = idx_sum - (ch_w+1)'(num_channels_p);
      idx = idx_sum[ch_w-1:0];
      if (!winner_v && v_i[idx]) begin
        winner   = idx;
        winner_v = 1'b1;
      end
    end
  end

  assign sel      = (state_q == XFER) ? owner_q : winner;
  assign sel_flit = data_i[sel*flit_width_p +: flit_width_p];
  assign sel_len  = sel_flit[len_width_p-1:0];
  assign space    = (fifo_cnt_q != 2'd2);
  assign accept   = |(v_i & ready_o);
  assign pop      = v_o & ready_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      owner_q     <= '0;
      ptr_q       <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (sel_len == '0) begin
            ptr_d = next_ptr(winner);
          end else begin
            state_d     = XFER;
            remaining_d = sel_len;
            owner_d     = winner;
          end
        end
      end
      XFER: begin
        if (accept) begin
          remaining_d = remaining_q - len_width_p'(1);
          if (remaining_q == len_width_p'(1)) begin
            state_d = IDLE;
            ptr_d   = next_ptr(owner_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready is gated by reset so nothing is accepted while reset is held
  always_comb begin
    ready_o = '0;
    grant_o = '0;
    busy_o  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (winner_v && !reset_i) ready_o[winner] = space;
      end
      XFER: begin
        if (!reset_i) ready_o[owner_q] = space;
        grant_o[owner_q] = 1'b1;
        busy_o           = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      fifo_wr_q  <= 1'b0;
      fifo_rd_q  <= 1'b0;
      fifo_cnt_q <= 2'd0;
    end else begin
      if (accept) fifo_wr_q <= ~fifo_wr_q;
      if (pop)    fifo_rd_q <= ~fifo_rd_q;
      unique case ({accept, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) fifo_mem[fifo_wr_q] <= sel_flit;
  end

  assign data_o = fifo_mem[fifo_rd_q];
  assign v_o    = (fifo_cnt_q != 2'd0);

endmodule

// File: tb/tb_bp_io_packet_arbiter.sv
// Randomized and directed bench for bp_io_packet_arbiter with a packet-level
// reference model and an output scoreboard.
module tb_bp_io_packet_arbiter;

  localparam int N = 4;
  localparam int W = 64;

  logic           clk = 1'b0;
  logic           reset_i;
  logic [N*W-1:0] data_i;
  logic [N-1:0]   v_i;
  logic [N-1:0]   ready_o;
  logic [W-1:0]   data_o;
  logic           v_o;
  logic           ready_i;
  logic [N-1:0]   grant_o;
  logic           busy_o;

  logic [N*W-1:0] fx_data;
  logic [N-1:0]   fx_v;
  logic [N-1:0]   fx_ready_o;
  logic [W-1:0]   fx_data_o;
  logic           fx_v_o;
  logic           fx_ready_i;
  logic [N-1:0]   fx_grant;
  logic           fx_busy;
  bit             fx_en = 1'b0;

  always #5 clk = ~clk;

  bp_io_packet_arbiter #(.num_channels_p(N), .flit_width_p(W), .len_width_p(4), .rr_mode_p(1'b1)) dut (
    .clk_i(clk), .reset_i(reset_i), .data_i(data_i), .v_i(v_i), .ready_o(ready_o),
    .data_o(data_o), .v_o(v_o), .ready_i(ready_i), .grant_o(grant_o), .busy_o(busy_o));

  bp_io_packet_arbiter #(.num_channels_p(N), .flit_width_p(W), .len_width_p(4), .rr_mode_p(1'b0)) dut_fix (
    .clk_i(clk), .reset_i(reset_i), .data_i(fx_data), .v_i(fx_v), .ready_o(fx_ready_o),
    .data_o(fx_data_o), .v_o(fx_v_o), .ready_i(fx_ready_i), .grant_o(fx_grant), .busy_o(fx_busy));

  int n_vec = 0;
  int n_err = 0;

  // stimulus sources and scoreboard
  logic [W-1:0] src_q [N][$];
  logic [W-1:0] exp_q [$];
  logic [N-1:0] valid_en = '1;
  logic         rdy = 1'b1;
  logic [N-1:0] hs;
  int           seq = 0;

  // reference model: packet-level arbitration state
  bit m_busy = 1'b0;
  int m_owner = 0;
  int m_rem = 0;
  int m_ptr = 0;
  int m_cnt = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic make_pkt(input int ch, input int len);
    seq++;
    src_q[ch].push_back({8'(ch), 16'(seq), 36'({$urandom(), $urandom()}), 4'(len)});
    for (int b = 0; b < len; b++)
      src_q[ch].push_back({8'(ch), 16'(seq), 8'(b + 1), 32'($urandom())});
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      v_i[k]          = valid_en[k] && (src_q[k].size() > 0);
      data_i[k*W +: W] = (src_q[k].size() > 0) ? src_q[k][0] : '0;
    end
    ready_i = rdy;
  endtask

  task automatic model_step();
    int w;
    bit sp, acc, pp;
    logic [N-1:0] er, eg;
    logic [W-1:0] f;
    sp = (m_cnt < 2);
    w  = -1;
    if (m_busy) w = m_owner;
    else
      for (int j = 0; j < N; j++) begin
        int k;
        k = (m_ptr + j) % N;
        if (w < 0 && v_i[k]) w = k;
      end
    er = '0;
    if (w >= 0 && sp) er[w] = 1'b1;
    eg = m_busy ? N'(1 << m_owner) : '0;
    check("ready_o", W'(ready_o), W'(er));
    check("grant_o", W'(grant_o), W'(eg));
    check("busy_o",  W'(busy_o),  W'(m_busy));
    check("v_o",     W'(v_o),     W'(m_cnt > 0));
    acc = (w >= 0) && sp && v_i[w];
    pp  = (m_cnt > 0) && ready_i;
    if (acc) begin
      f = data_i[w*W +: W];
      exp_q.push_back(f);
      if (!m_busy) begin
        if (f[3:0] == 4'd0) m_ptr = (w + 1) % N;
        else begin
          m_busy  = 1'b1;
          m_owner = w;
          m_rem   = int'(f[3:0]);
        end
      end else begin
        m_rem--;
        if (m_rem == 0) begin
          m_busy = 1'b0;
          m_ptr  = (m_owner + 1) % N;
        end
      end
    end
    m_cnt = m_cnt + int'(acc) - int'(pp);
  endtask

  // one clock: drive after the edge, model/compare on the falling edge, retire handshakes
  task automatic step();
    drive();
    @(negedge clk);
    model_step();
    hs = v_i & ready_o;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++)
      if (hs[k]) void'(src_q[k].pop_front());
  endtask

  function automatic bit all_empty();
    for (int k = 0; k < N; k++)
      if (src_q[k].size() != 0) return 1'b0;
    return (m_cnt == 0) && (exp_q.size() == 0);
  endfunction

  task automatic drain(input string name);
    int c;
    valid_en = '1;
    rdy      = 1'b1;
    c        = 0;
    while (!all_empty() && c < 2000) begin
      step();
      c++;
    end
    if (!all_empty()) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: got %0d pending expected 0", name, exp_q.size());
    end
  endtask

  // output scoreboard monitor
  always @(negedge clk) begin
    if (!reset_i && v_o && ready_i) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL data_o: got %h expected no flit", data_o);
      end else begin
        check("data_o", data_o, exp_q.pop_front());
      end
    end
  end

  // fixed-priority instance: ch0 and ch3 always valid, only ch0 may ever win
  always @(negedge clk) begin
    if (!reset_i && fx_en) begin
      check("fx_ready", W'(fx_ready_o), W'(4'b0001));
      check("fx_busy", W'(fx_busy), '0);
      if (fx_v_o) check("fx_src", W'(fx_data_o[63:56]), '0);
    end
  end

  initial begin
    int c, n_hs;
    reset_i    = 1'b1;
    v_i        = '0;
    data_i     = '0;
    ready_i    = 1'b0;
    fx_v       = 4'b1001;
    fx_ready_i = 1'b1;
    fx_data    = '0;
    fx_data[3*W +: W] = {8'd3, 56'd0};
    #12;
    check("rst_v_o",     W'(v_o),     '0);
    check("rst_ready_o", W'(ready_o), '0);
    check("rst_grant_o", W'(grant_o), '0);
    check("rst_busy_o",  W'(busy_o),  '0);
    @(posedge clk);
    #1 reset_i = 1'b0;

    // single-flit packets, all channels, round-robin order
    fx_en = 1'b1;
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < N; k++) make_pkt(k, 0);
    drain("single");
    fx_en = 1'b0;

    // packet atomicity: ch2 long packet with ch0 contending
    make_pkt(2, 3);
    make_pkt(0, 0);
    make_pkt(0, 0);
    drain("atomic");

    // owner stall mid-packet with ch3 contending
    make_pkt(1, 3);
    for (int r = 0; r < 3; r++) make_pkt(3, 0);
    c = 0;
    while (!(m_busy && m_owner == 1 && m_rem == 2) && c < 40) begin
      step();
      c++;
    end
    check("stall_reached", W'(m_busy && m_owner == 1 && m_rem == 2), W'(1));
    valid_en = 4'b1101;
    for (int s = 0; s < 5; s++) step();
    drain("stall");

    // backpressure during an 8-flit packet
    make_pkt(0, 7);
    rdy  = 1'b0;
    n_hs = 0;
    for (int s = 0; s < 10; s++) begin
      step();
      n_hs += $countones(hs);
    end
    check("bp_accepts", W'(n_hs), W'(2));
    drain("bp");

    // randomized traffic
    for (int s = 0; s < 400; s++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 9) == 0 && src_q[k].size() < 24) make_pkt(k, int'($urandom_range(0, 15)));
        valid_en[k] = ($urandom_range(0, 9) < 8);
      end
      rdy = ($urandom_range(0, 3) != 0);
      step();
    end
    drain("random");

    // asynchronous reset mid-packet with two flits buffered
    make_pkt(1, 7);
    rdy = 1'b0;
    c   = 0;
    while (m_cnt != 2 && c < 10) begin
      step();
      c++;
    end
    check("rst_fill", W'(m_cnt), W'(2));
    #2 reset_i = 1'b1;
    #1;
    check("arst_v_o",     W'(v_o),     '0);
    check("arst_ready_o", W'(ready_o), '0);
    check("arst_grant_o", W'(grant_o), '0);
    check("arst_busy_o",  W'(busy_o),  '0);
    for (int k = 0; k < N; k++) src_q[k].delete();
    exp_q.delete();
    m_busy = 1'b0; m_owner = 0; m_rem = 0; m_ptr = 0; m_cnt = 0;
    drive();
    @(posedge clk);
    #1 reset_i = 1'b0;
    make_pkt(3, 0);
    make_pkt(0, 0);
    rdy      = 1'b1;
    valid_en = '1;
    step();
    check("post_rst_first", W'(hs), W'(4'b0001));
    drain("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
